// File: rtl/core_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, FSM states
// and small helpers used by the fetch control and its output buffer.
package core_ifu_pkg;

    localparam int CPU_PC_SIZE   = 64;
    localparam int CPU_INST_SIZE = 32;
    localparam int IFU_PC_INC    = 4;

    // Fetch sequencer states; encodings match the core-wide defines.
    typedef enum logic [2:0] {
        IFU_ST_IDLE  = 3'd0,
        IFU_ST_REQ   = 3'd1,
        IFU_ST_WAIT  = 3'd2,
        IFU_ST_DRAIN = 3'd3,
        IFU_ST_HALT  = 3'd4
    } ifu_state_e;

    // Instructions are 32-bit aligned; anything else raises a fetch fault.
    function automatic logic isAligned(input logic [1:0] lowBits);
        return (lowBits == 2'b00);
    endfunction

endpackage

// File: rtl/core_ifu_buf.sv
// One-entry valid/ready holding register between fetch and decode.
// Clear beats load, load beats consume; contents hold while presented
// and not yet taken.
module core_ifu_buf
    import core_ifu_pkg::*;
#(
    parameter int XLEN = CPU_PC_SIZE,
    parameter int ILEN = CPU_INST_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_ldPc,
    input  logic [ILEN-1:0] i_ldInst,
    input  logic            i_ldFault,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [ILEN-1:0] o_inst,
    output logic            o_fault
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_inst;
    logic            r_fault;

    // Full flag: cleared by a redirect, set by a load, dropped when decode takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload only changes on a load so a stalled entry stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_inst  <= '0;
            r_fault <= 1'b0;
        end else if (i_load && !i_clear) begin
            r_pc    <= i_ldPc;
            r_inst  <= i_ldInst;
            r_fault <= i_ldFault;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_fault = r_fault;

endmodule

// File: rtl/core_ifu.sv
// Instruction fetch unit: sole writer of the PC register, keeps at most one
// instruction-memory request in flight and hands fetched instructions to
// decode through a one-entry buffer. Redirects from execute override
// sequential fetch and cause stale responses to be dropped.
module core_ifu
    import core_ifu_pkg::*;
#(
    parameter int XLEN = CPU_PC_SIZE,
    parameter int ILEN = CPU_INST_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_cur_i,
    output logic [XLEN-1:0] pc_nxt_o,
    output logic            pc_wen_o,
    input  logic            redir_valid_i,
    input  logic [XLEN-1:0] redir_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [ILEN-1:0] id_inst_o,
    output logic            id_fault_o
);

    ifu_state_e      r_state;
    ifu_state_e      w_stateNext;
    logic [XLEN-1:0] r_inflightPc;

    logic            w_canAccept;
    logic            w_aligned;
    logic            w_latchInflight;
    logic            w_bufLoad;
    logic            w_bufClear;
    logic [XLEN-1:0] w_ldPc;
    logic [ILEN-1:0] w_ldInst;
    logic            w_ldFault;

    // The buffer can take a new entry if it is empty or is being drained now.
    assign w_canAccept = !id_valid_o || id_ready_i;
    assign w_aligned   = isAligned(pc_cur_i[1:0]);

    // Next-state, memory request, PC write and buffer load decisions.
    always_comb begin
        w_stateNext      = r_state;
        imem_req_valid_o = 1'b0;
        imem_req_addr_o  = '0;
        pc_wen_o         = 1'b0;
        pc_nxt_o         = '0;
        w_latchInflight  = 1'b0;
        w_bufLoad        = 1'b0;
        w_bufClear       = 1'b0;
        w_ldPc           = '0;
        w_ldInst         = '0;
        w_ldFault        = 1'b0;

        if (r_state == IFU_ST_IDLE) begin
            w_stateNext = IFU_ST_REQ;
        end else if (redir_valid_i) begin
            pc_wen_o   = 1'b1;
            pc_nxt_o   = redir_pc_i;
            w_bufClear = 1'b1;
            case (r_state)
                IFU_ST_WAIT,
                IFU_ST_DRAIN: w_stateNext = imem_rsp_valid_i ? IFU_ST_REQ : IFU_ST_DRAIN;
                default:      w_stateNext = IFU_ST_REQ;
            endcase
        end else begin
            case (r_state)
                IFU_ST_REQ: begin
                    imem_req_addr_o = pc_cur_i;
                    if (w_aligned) begin
                        imem_req_valid_o = w_canAccept;
                        if (w_canAccept && imem_req_ready_i) begin
                            pc_wen_o        = 1'b1;
                            pc_nxt_o        = pc_cur_i + XLEN'(IFU_PC_INC);
                            w_latchInflight = 1'b1;
                            w_stateNext     = IFU_ST_WAIT;
                        end
                    end else if (w_canAccept) begin
                        w_bufLoad   = 1'b1;
                        w_ldPc      = pc_cur_i;
                        w_ldFault   = 1'b1;
                        w_stateNext = IFU_ST_HALT;
                    end
                end
                IFU_ST_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        w_bufLoad   = 1'b1;
                        w_ldPc      = r_inflightPc;
                        w_ldInst    = imem_rsp_data_i;
                        w_ldFault   = imem_rsp_err_i;
                        w_stateNext = imem_rsp_err_i ? IFU_ST_HALT : IFU_ST_REQ;
                    end
                end
                IFU_ST_DRAIN: begin
                    if (imem_rsp_valid_i) begin
                        w_stateNext = IFU_ST_REQ;
                    end
                end
                default: begin
                    w_stateNext = r_state;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IFU_ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Remember the address of the outstanding request for tagging its response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflightPc <= '0;
        end else if (w_latchInflight) begin
            r_inflightPc <= pc_cur_i;
        end
    end

    core_ifu_buf #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_bufLoad),
        .i_clear   (w_bufClear),
        .i_ldPc    (w_ldPc),
        .i_ldInst  (w_ldInst),
        .i_ldFault (w_ldFault),
        .i_ready   (id_ready_i),
        .o_valid   (id_valid_o),
        .o_pc      (id_pc_o),
        .o_inst    (id_inst_o),
        .o_fault   (id_fault_o)
    );

endmodule
